// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes and fetch FSM states.
package pc_fetch_unit_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] PC_4     = 2'b00;
   localparam logic [1:0] PC_14BIT = 2'b01;
   localparam logic [1:0] PC_24BIT = 2'b10;
   localparam logic [1:0] PC_HOLD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_calc.sv
// Combinational next-PC: sign-extends halfword offsets, scales to bytes, adds modulo 2^32.
module next_pc_calc
   import pc_fetch_unit_pkg::*;
(
   input  logic [XLEN-1:0] pc,
   input  logic [1:0]      pc_select,
   input  logic [13:0]     imm_14bit,
   input  logic [23:0]     imm_24bit,
   output logic [XLEN-1:0] next_pc_c
);

   logic [XLEN-1:0] off14_c;
   logic [XLEN-1:0] off24_c;

   assign off14_c = {{(XLEN-15){imm_14bit[13]}}, imm_14bit, 1'b0};
   assign off24_c = {{(XLEN-25){imm_24bit[23]}}, imm_24bit, 1'b0};

   always_comb begin
      next_pc_c = pc;
      case (pc_select)
         PC_4:     next_pc_c = pc + XLEN'(4);
         PC_14BIT: next_pc_c = pc + off14_c;
         PC_24BIT: next_pc_c = pc + off24_c;
         default:  next_pc_c = pc;
      endcase
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches over a ready handshake.
// Optional alignment fault reporting is enabled by defining FETCH_ALIGN_CHECK_EN.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned IM_ADDR_W = 10,
   parameter logic [31:0] IR_RESET  = 32'h0000_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enable_fetch,
   input  logic                 enable_writeback,
   input  logic [1:0]           pc_select,
   input  logic [13:0]          imm_14bit,
   input  logic [23:0]          imm_24bit,
   output logic [IM_ADDR_W-1:0] im_addr,
   output logic                 im_read,
   input  logic                 im_ready,
   input  logic [31:0]          im_rdata,
   output logic [31:0]          instruction,
   output logic [31:0]          pc,
`ifdef FETCH_ALIGN_CHECK_EN
   output logic                 misalign_fault,
`endif
   output logic                 fetch_busy,
   output logic                 fetch_done
);

   fetch_state_t    state;
   fetch_state_t    state_nxt;
   logic            im_read_nxt;
   logic            fetch_done_nxt;
   logic            capture_c;
   logic            latch_c;
   logic [31:0]     next_pc_c;
`ifdef FETCH_ALIGN_CHECK_EN
   logic            fault_set_c;
`endif

   next_pc_calc u_next_pc_calc (
      .pc        (pc),
      .pc_select (pc_select),
      .imm_14bit (imm_14bit),
      .imm_24bit (imm_24bit),
      .next_pc_c (next_pc_c)
   );

   // Next-state and next-output decode
   always_comb begin
      state_nxt      = state;
      im_read_nxt    = 1'b0;
      fetch_done_nxt = 1'b0;
      capture_c      = 1'b0;
      latch_c        = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_set_c    = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (enable_fetch) begin
`ifdef FETCH_ALIGN_CHECK_EN
               if (pc[1:0] != 2'b00) begin
                  fault_set_c = 1'b1;
               end else begin
                  state_nxt   = ST_REQ;
                  im_read_nxt = 1'b1;
                  capture_c   = 1'b1;
               end
`else
               state_nxt   = ST_REQ;
               im_read_nxt = 1'b1;
               capture_c   = 1'b1;
`endif
            end
         end
         ST_REQ, ST_WAIT: begin
            if (im_ready) begin
               state_nxt      = ST_IDLE;
               latch_c        = 1'b1;
               fetch_done_nxt = 1'b1;
            end else begin
               state_nxt   = ST_WAIT;
               im_read_nxt = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs; im_addr captures the pre-writeback PC at REQ entry
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         im_read     <= 1'b0;
         fetch_busy  <= 1'b0;
         fetch_done  <= 1'b0;
         im_addr     <= RESET_PC[IM_ADDR_W+1:2];
         instruction <= IR_RESET;
         pc          <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign_fault <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         im_read    <= im_read_nxt;
         fetch_busy <= (state_nxt != ST_IDLE);
         fetch_done <= fetch_done_nxt;
         if (capture_c) im_addr <= pc[IM_ADDR_W+1:2];
         if (latch_c) instruction <= im_rdata;
         if (enable_writeback) pc <= next_pc_c;
`ifdef FETCH_ALIGN_CHECK_EN
         if (fault_set_c) misalign_fault <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (covers FETCH_ALIGN_CHECK_EN when defined).
module tb_pc_fetch_unit;

   localparam int unsigned IM_ADDR_W = 10;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 enable_fetch;
   logic                 enable_writeback;
   logic [1:0]           pc_select;
   logic [13:0]          imm_14bit;
   logic [23:0]          imm_24bit;
   logic [IM_ADDR_W-1:0] im_addr;
   logic                 im_read;
   logic                 im_ready;
   logic [31:0]          im_rdata;
   logic [31:0]          instruction;
   logic [31:0]          pc;
   logic                 fetch_busy;
   logic                 fetch_done;
`ifdef FETCH_ALIGN_CHECK_EN
   logic                 misalign_fault;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   pc_fetch_unit dut (
      .clock            (clock),
      .reset            (reset),
      .enable_fetch     (enable_fetch),
      .enable_writeback (enable_writeback),
      .pc_select        (pc_select),
      .imm_14bit        (imm_14bit),
      .imm_24bit        (imm_24bit),
      .im_addr          (im_addr),
      .im_read          (im_read),
      .im_ready         (im_ready),
      .im_rdata         (im_rdata),
      .instruction      (instruction),
      .pc               (pc),
`ifdef FETCH_ALIGN_CHECK_EN
      .misalign_fault   (misalign_fault),
`endif
      .fetch_busy       (fetch_busy),
      .fetch_done       (fetch_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic writeback(input logic [1:0] sel, input logic [13:0] i14, input logic [23:0] i24);
      enable_writeback = 1'b1;
      pc_select        = sel;
      imm_14bit        = i14;
      imm_24bit        = i24;
      step();
      enable_writeback = 1'b0;
   endtask

   initial begin
      reset            = 1'b1;
      enable_fetch     = 1'b0;
      enable_writeback = 1'b0;
      pc_select        = 2'b00;
      imm_14bit        = '0;
      imm_24bit        = '0;
      im_ready         = 1'b0;
      im_rdata         = '0;
      #3;
      chk("rst_pc", pc, 32'h0);
      chk("rst_ir", instruction, 32'h0);
      chk("rst_im_read", 32'(im_read), 32'h0);
      chk("rst_busy", 32'(fetch_busy), 32'h0);
      chk("rst_done", 32'(fetch_done), 32'h0);
      chk("rst_im_addr", 32'(im_addr), 32'h0);
      step();
      reset = 1'b0;

      // zero-wait fetch
      im_ready     = 1'b1;
      im_rdata     = 32'h0A10_0005;
      enable_fetch = 1'b1;
      step();
      enable_fetch = 1'b0;
      chk("f0_im_read", 32'(im_read), 32'h1);
      chk("f0_im_addr", 32'(im_addr), 32'h0);
      chk("f0_busy", 32'(fetch_busy), 32'h1);
      chk("f0_done_early", 32'(fetch_done), 32'h0);
      step();
      chk("f0_ir", instruction, 32'h0A10_0005);
      chk("f0_done", 32'(fetch_done), 32'h1);
      chk("f0_im_read_off", 32'(im_read), 32'h0);
      chk("f0_busy_off", 32'(fetch_busy), 32'h0);
      step();
      chk("f0_done_pulse", 32'(fetch_done), 32'h0);

      // move PC to 4, then a fetch with 3 wait cycles and a writeback mid-flight
      writeback(2'b00, '0, '0);
      chk("wb_pc4", pc, 32'h4);
      im_ready     = 1'b0;
      im_rdata     = 32'h1234_5678;
      enable_fetch = 1'b1;
      step();
      chk("w_im_read_req", 32'(im_read), 32'h1);
      chk("w_im_addr_req", 32'(im_addr), 32'h1);
      for (int i = 0; i < 3; i++) begin
         if (i == 1) enable_writeback = 1'b1;
         step();
         enable_writeback = 1'b0;
         chk("w_im_read", 32'(im_read), 32'h1);
         chk("w_im_addr", 32'(im_addr), 32'h1);
         chk("w_ir_held", instruction, 32'h0A10_0005);
         chk("w_busy", 32'(fetch_busy), 32'h1);
      end
      chk("w_pc_updated", pc, 32'h8);
      enable_fetch = 1'b0;
      im_ready     = 1'b1;
      step();
      chk("w_ir", instruction, 32'h1234_5678);
      chk("w_done", 32'(fetch_done), 32'h1);
      chk("w_im_read_off", 32'(im_read), 32'h0);
      step();
      chk("w_no_requeue", 32'(im_read), 32'h0);
      chk("w_idle", 32'(fetch_busy), 32'h0);

      // fetch and writeback together: PC updates, fetch uses old PC
      im_rdata         = 32'hAABB_CCDD;
      enable_fetch     = 1'b1;
      enable_writeback = 1'b1;
      pc_select        = 2'b00;
      step();
      enable_fetch     = 1'b0;
      enable_writeback = 1'b0;
      chk("same_pc", pc, 32'hC);
      chk("same_im_addr", 32'(im_addr), 32'h2);
      step();
      chk("same_ir", instruction, 32'hAABB_CCDD);

      // next-PC arithmetic around 0x100
      writeback(2'b10, '0, 24'h00007A);
      chk("pc_to_100", pc, 32'h100);
      writeback(2'b11, 14'h0001, 24'h000001);
      chk("sel11_hold", pc, 32'h100);
      writeback(2'b00, '0, '0);
      chk("sel00", pc, 32'h104);
      writeback(2'b01, 14'h3FFE, '0);
      chk("sel01_back", pc, 32'h100);
      writeback(2'b01, 14'h3FFE, '0);
      chk("sel01_neg", pc, 32'hFC);
      writeback(2'b10, '0, 24'h000002);
      chk("sel10_back", pc, 32'h100);
      writeback(2'b10, '0, 24'h000010);
      chk("sel10", pc, 32'h120);
      writeback(2'b10, '0, 24'hFFFFF0);
      chk("sel10_neg", pc, 32'h100);

      // wrap
      writeback(2'b10, '0, 24'hFFFF7E);
      chk("pc_to_top", pc, 32'hFFFF_FFFC);
      writeback(2'b00, '0, '0);
      chk("wrap", pc, 32'h0);
      pc_select = 2'b00;
      step();
      chk("no_wb_hold", pc, 32'h0);

      // reset asserted mid-WAIT
      im_ready     = 1'b0;
      im_rdata     = 32'hDEAD_BEEF;
      enable_fetch = 1'b1;
      step();
      enable_fetch = 1'b0;
      step();
      chk("mid_busy", 32'(fetch_busy), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_im_read", 32'(im_read), 32'h0);
      chk("async_busy", 32'(fetch_busy), 32'h0);
      chk("async_ir", instruction, 32'h0);
      step();
      reset    = 1'b0;
      im_ready = 1'b1;
      step();
      step();
      chk("late_ready_ir", instruction, 32'h0);
      chk("late_ready_done", 32'(fetch_done), 32'h0);
      chk("late_ready_read", 32'(im_read), 32'h0);
      im_ready = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
      chk("mf_rst", 32'(misalign_fault), 32'h0);
      writeback(2'b10, '0, 24'h000081);
      chk("mf_pc", pc, 32'h102);
      enable_fetch = 1'b1;
      step();
      enable_fetch = 1'b0;
      chk("mf_set", 32'(misalign_fault), 32'h1);
      chk("mf_no_read", 32'(im_read), 32'h0);
      chk("mf_idle", 32'(fetch_busy), 32'h0);
      step();
      step();
      chk("mf_sticky", 32'(misalign_fault), 32'h1);
      chk("mf_no_done", 32'(fetch_done), 32'h0);
      reset = 1'b1;
      #1;
      chk("mf_cleared", 32'(misalign_fault), 32'h0);
      step();
      reset = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage of the 5-state multi-cycle core; sits directly upstream of the controller and feeds it its instruction word.
- Owns the PC and the instruction register.
- Fetches from instruction memory with a ready handshake when the controller strobes enable_fetch.
- Updates the PC on the writeback strobe using the controller's pc_select and branch/jump immediates.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word-aligned).
- IM_ADDR_W, 10, width of IM word address; im_addr = pc[IM_ADDR_W+1:2].
- IR_RESET, 32'h0000_0000, instruction register reset value (decodes as no-write default).

Ports:
- clock  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable_fetch  in  1  controller fetch-state strobe, one cycle.
- enable_writeback  in  1  controller writeback-state strobe; PC update point.
- pc_select  in  2  next-PC source: 00 PC+4, 01 PC+branch14, 10 PC+jump24, 11 reserved.
- imm_14bit  in  14  branch offset in halfwords, signed.
- imm_24bit  in  24  jump offset in halfwords, signed.
- im_addr  out  IM_ADDR_W  IM word address.
- im_read  out  1  IM read request.
- im_ready  in  1  IM data valid this cycle.
- im_rdata  in  32  IM read data.
- instruction  out  32  instruction register to controller/decoder.
- pc  out  32  current PC.
- fetch_busy  out  1  high while a fetch is outstanding.
- fetch_done  out  1  one-cycle pulse when instruction is latched.

Behaviour:
- Reset, asynchronous: pc=RESET_PC, instruction=IR_RESET, state=IDLE, im_read=0, fetch_busy=0, fetch_done=0, im_addr=RESET_PC[IM_ADDR_W+1:2].
- FSM states: IDLE, REQ, WAIT.
  - IDLE: enable_fetch=1 -> REQ.
  - REQ: im_read=1, im_addr from pc. If im_ready -> latch im_rdata into instruction, pulse fetch_done next cycle, go to IDLE; else -> WAIT.
  - WAIT: im_read stays 1 and im_addr is held stable. On im_ready -> latch, fetch_done, go to IDLE.
- Latency: 1 cycle from enable_fetch to im_read. With zero wait states, instruction is valid 2 cycles after enable_fetch. Each IM wait cycle adds 1.
- fetch_busy = (state != IDLE).
- enable_fetch while busy is ignored; no queuing.
- instruction is held constant except at a latch. The controller decodes combinationally from it through decode, execute, memaccess and writeback.
- PC update occurs only on enable_writeback:
  - 00: pc+4.
  - 01: pc + (sext(imm_14bit)<<1).
  - 10: pc + (sext(imm_24bit)<<1).
  - 11: pc unchanged.
- All PC arithmetic is 32-bit two's complement and wraps modulo 2^32, with no overflow flag.
- enable_writeback while busy: the PC update still occurs. The in-flight fetch keeps the im_addr it captured at REQ, so the address is registered at REQ entry.
- enable_fetch and enable_writeback in the same cycle: the PC update wins the register. The fetch uses the pre-update PC.
- Reset mid-fetch: the transaction is abandoned and im_read drops immediately (asynchronous). A late im_ready after reset is ignored.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- With the macro defined:
  - Extra output misalign_fault (1 bit, sticky, cleared only by reset).
  - It is set when enable_fetch arrives with pc[1:0]!=0. That fetch is suppressed: stays IDLE, no im_read, no fetch_done.
  - A halfword-aligned branch target is therefore reported instead of silently truncated.
- Without the macro: no port. pc[1:0] are ignored for addressing and the fetch proceeds.

Decomposition:
- Shared package/defines (def_muxs): PC_4, PC_14BIT, PC_24BIT encodings, plus fetch FSM state constants.
- One natural sub-module, next_pc_calc: combinational sign-extend/shift/add producing the next PC from pc, pc_select, imm_14bit and imm_24bit. It is reusable by a future pipelined front end.

Test Plan:
- Reset then enable_fetch, im_ready tied 1:
  - im_read asserted 1 cycle later with im_addr=0.
  - im_rdata=32'h0A10_0005 latched; fetch_done pulses once.
- Fetch with 3 IM wait cycles: im_addr is stable throughout WAIT, im_read stays high 4 cycles, instruction updates only on the im_ready cycle.
- PC updates from pc=0x100 at enable_writeback:
  - pc_select=00 -> 0x104.
  - pc_select=01 with imm_14bit=14'h3FFE -> 0xFC.
  - pc_select=10 with imm_24bit=24'h000010 -> 0x120.
  - pc_select=11 -> pc stays 0x100.
- Wrap: pc=0xFFFF_FFFC, pc_select=00 -> pc=0x0000_0000.
- Reset asserted mid-WAIT: im_read drops and fetch_busy=0 asynchronously; a later im_ready does not change instruction.
- FETCH_ALIGN_CHECK_EN on: pc=0x102 then enable_fetch -> misalign_fault=1, no im_read, fault holds until reset.
